y_opfetch: RTL and testbench

Y_OPFETCH -- requirements
Module: y_opfetch

---
 rtl/y_opfetch_if.sv | 39 +++
 rtl/y_opfetch.sv | 107 ++++++++++
 tb/tb_y_opfetch.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/y_opfetch_if.sv
// Operand-fetch stage bus: request in, writeback, and operand handoff to the ALU.
interface y_opfetch_if;
    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OPW  = 3;

    logic            in_valid;
    logic            in_ready;
    logic [AW-1:0]   in_rs1;
    logic [AW-1:0]   in_rs2;
    logic [OPW-1:0]  in_op;
    logic [XLEN-1:0] in_imm;
    logic            in_use_imm;

    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [XLEN-1:0] wr_data;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [OPW-1:0]  out_op;
    logic            out_ill;

    modport master (
        output in_valid, in_rs1, in_rs2, in_op, in_imm, in_use_imm,
        output wr_en, wr_addr, wr_data,
        output out_ready,
        input  in_ready, out_valid, out_a, out_b, out_op, out_ill
    );

    modport slave (
        input  in_valid, in_rs1, in_rs2, in_op, in_imm, in_use_imm,
        input  wr_en, wr_addr, wr_data,
        input  out_ready,
        output in_ready, out_valid, out_a, out_b, out_op, out_ill
    );
endinterface

// File: rtl/y_opfetch.sv
// Operand fetch: 32x32 register file with writeback bypass and a one-entry
// output register that refreshes its operands from writes while stalled.
module y_opfetch #(
    parameter bit ZERO_REG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    y_opfetch_if.slave  bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned OPW  = 3;

    logic [XLEN-1:0] regs [NREG];

    logic            valid_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [OPW-1:0]  op_q;
    logic            ill_q;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic            use_imm_q;

    logic            in_ready_c;
    logic            accept_c;
    logic            wr_ok_c;
    logic            zero1_c;
    logic            zero2_c;
    logic            hit1_c;
    logic            hit2_c;
    logic            hold_hit1_c;
    logic            hold_hit2_c;
    logic            ill_c;
    logic [XLEN-1:0] rd_a_c;
    logic [XLEN-1:0] rd_b_c;

    assign in_ready_c = !valid_q || bus.out_ready;
    assign accept_c   = bus.in_valid && in_ready_c;

    // Index 0 is hardwired only when ZERO_REG is set.
    assign wr_ok_c = bus.wr_en && !(ZERO_REG && (bus.wr_addr == AW'(0)));
    assign zero1_c = ZERO_REG && (bus.in_rs1 == AW'(0));
    assign zero2_c = ZERO_REG && (bus.in_rs2 == AW'(0));

    assign hit1_c      = wr_ok_c && (bus.wr_addr == bus.in_rs1);
    assign hit2_c      = wr_ok_c && (bus.wr_addr == bus.in_rs2);
    assign hold_hit1_c = wr_ok_c && (bus.wr_addr == rs1_q);
    assign hold_hit2_c = wr_ok_c && (bus.wr_addr == rs2_q) && !use_imm_q;

    assign ill_c = (bus.in_op == 3'b011) || (bus.in_op == 3'b100) || (bus.in_op == 3'b101);

    // Read ports with same-cycle writeback forwarding.
    always_comb begin
        rd_a_c = regs[bus.in_rs1];
        rd_b_c = regs[bus.in_rs2];
        if (hit1_c) rd_a_c = bus.wr_data;
        if (hit2_c) rd_b_c = bus.wr_data;
        if (zero1_c) rd_a_c = '0;
        if (zero2_c) rd_b_c = '0;
        if (bus.in_use_imm) rd_b_c = bus.in_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
        end else if (wr_ok_c) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Output entry: load on accept, drain on consume, refresh from writes while held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            ill_q     <= 1'b0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_imm_q <= 1'b0;
        end else if (accept_c) begin
            valid_q   <= 1'b1;
            a_q       <= rd_a_c;
            b_q       <= rd_b_c;
            op_q      <= bus.in_op;
            ill_q     <= ill_c;
            rs1_q     <= bus.in_rs1;
            rs2_q     <= bus.in_rs2;
            use_imm_q <= bus.in_use_imm;
        end else if (valid_q && bus.out_ready) begin
            valid_q <= 1'b0;
        end else if (valid_q) begin
            if (hold_hit1_c) a_q <= bus.wr_data;
            if (hold_hit2_c) b_q <= bus.wr_data;
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = valid_q;
    assign bus.out_a     = a_q;
    assign bus.out_b     = b_q;
    assign bus.out_op    = op_q;
    assign bus.out_ill   = ill_q;
endmodule

// File: tb/tb_y_opfetch.sv
// Directed vector bench for y_opfetch: table of cycle steps plus a reset-mid-stream sequence.
module tb_y_opfetch;
    logic clk = 1'b0;
    logic rst_n;
    int   n_pass = 0;
    int   n_total = 0;

    y_opfetch_if bus ();

    y_opfetch #(.ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iv;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [2:0]  op;
        logic [31:0] imm;
        logic        ui;
        logic        ordy;
        logic        e_ir;
        logic        e_v;
        logic        cd;
        logic [31:0] ea;
        logic [31:0] eb;
        logic [2:0]  eop;
        logic        eill;
    } vec_t;

    vec_t tv[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name,
                                input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                                input logic [2:0] op, input logic [31:0] imm, input logic ui,
                                input logic ordy, input logic e_ir, input logic e_v,
                                input logic cd, input logic [31:0] ea, input logic [31:0] eb,
                                input logic [2:0] eop, input logic eill);
        vec_t v;
        v.name = name; v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.r1 = r1; v.r2 = r2;
        v.op = op; v.imm = imm; v.ui = ui; v.ordy = ordy; v.e_ir = e_ir; v.e_v = e_v;
        v.cd = cd; v.ea = ea; v.eb = eb; v.eop = eop; v.eill = eill;
        return v;
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic iv, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [2:0] op, input logic [31:0] imm, input logic ui,
                         input logic ordy);
        bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
        bus.in_valid = iv; bus.in_rs1 = r1; bus.in_rs2 = r2; bus.in_op = op;
        bus.in_imm = imm; bus.in_use_imm = ui; bus.out_ready = ordy;
    endtask

    initial begin
        //          name        we wa  wd            iv r1 r2 op      imm     ui rdy  ir v  cd a             b         op      ill
        tv.push_back(mk("wr_r3",   1, 3, 32'h5,        0, 0, 0, 3'b000, 0,      0, 1,  1, 0, 0, 0,            0,        3'b000, 0));
        tv.push_back(mk("wr_r4",   1, 4, 32'h7,        0, 0, 0, 3'b000, 0,      0, 1,  1, 0, 0, 0,            0,        3'b000, 0));
        tv.push_back(mk("issue",   0, 0, 0,            1, 3, 4, 3'b010, 0,      0, 1,  1, 1, 1, 32'h5,        32'h7,    3'b010, 0));
        tv.push_back(mk("bypass",  1, 5, 32'hDEADBEEF, 1, 5, 3, 3'b000, 0,      0, 1,  1, 1, 1, 32'hDEADBEEF, 32'h5,    3'b000, 0));
        tv.push_back(mk("drain",   1, 6, 32'h1,        0, 0, 0, 3'b000, 0,      0, 1,  1, 0, 0, 0,            0,        3'b000, 0));
        tv.push_back(mk("ld_r6",   0, 0, 0,            1, 6, 0, 3'b111, 0,      0, 0,  1, 1, 1, 32'h1,        32'h0,    3'b111, 0));
        tv.push_back(mk("refresh", 1, 6, 32'h9,        1, 3, 4, 3'b001, 0,      0, 0,  0, 1, 1, 32'h9,        32'h0,    3'b111, 0));
        tv.push_back(mk("wr_r0",   1, 0, 32'hFFFFFFFF, 0, 0, 0, 3'b000, 0,      0, 0,  0, 1, 1, 32'h9,        32'h0,    3'b111, 0));
        tv.push_back(mk("zero_rd", 1, 0, 32'h1234,     1, 0, 0, 3'b010, 0,      0, 1,  1, 1, 1, 32'h0,        32'h0,    3'b010, 0));
        tv.push_back(mk("imm_ill", 0, 0, 0,            1, 4, 3, 3'b100, 32'h10, 1, 1,  1, 1, 1, 32'h7,        32'h10,   3'b100, 1));
        tv.push_back(mk("imm_hld", 1, 3, 32'hAAAA,     0, 0, 0, 3'b000, 0,      0, 0,  0, 1, 1, 32'h7,        32'h10,   3'b100, 1));
        tv.push_back(mk("a_rfrsh", 1, 4, 32'h55,       0, 0, 0, 3'b000, 0,      0, 0,  0, 1, 1, 32'h55,       32'h10,   3'b100, 1));
        tv.push_back(mk("ill_011", 0, 0, 0,            1, 3, 4, 3'b011, 0,      0, 1,  1, 1, 1, 32'hAAAA,     32'h55,   3'b011, 1));
        tv.push_back(mk("ill_101", 0, 0, 0,            1, 5, 6, 3'b101, 0,      0, 1,  1, 1, 1, 32'hDEADBEEF, 32'h9,    3'b101, 1));
        tv.push_back(mk("sub",     0, 0, 0,            1, 1, 2, 3'b110, 0,      0, 1,  1, 1, 1, 32'h0,        32'h0,    3'b110, 0));
        tv.push_back(mk("strm0",   0, 0, 0,            1, 3, 4, 3'b000, 0,      0, 1,  1, 1, 1, 32'hAAAA,     32'h55,   3'b000, 0));
        tv.push_back(mk("strm1",   0, 0, 0,            1, 4, 3, 3'b001, 0,      0, 1,  1, 1, 1, 32'h55,       32'hAAAA, 3'b001, 0));
        tv.push_back(mk("strm2",   0, 0, 0,            1, 5, 4, 3'b010, 0,      0, 1,  1, 1, 1, 32'hDEADBEEF, 32'h55,   3'b010, 0));
        tv.push_back(mk("strm3",   0, 0, 0,            1, 6, 5, 3'b111, 0,      0, 1,  1, 1, 1, 32'h9,        32'hDEADBEEF, 3'b111, 0));

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 0);
        #2;
        check("rst_valid", 32'(bus.out_valid), 32'h0);
        check("rst_a", bus.out_a, 32'h0);
        check("rst_b", bus.out_b, 32'h0);
        check("rst_in_ready", 32'(bus.in_ready), 32'h1);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (tv[i]) begin
            drive(tv[i].we, tv[i].wa, tv[i].wd, tv[i].iv, tv[i].r1, tv[i].r2,
                  tv[i].op, tv[i].imm, tv[i].ui, tv[i].ordy);
            #1;
            check({tv[i].name, ".in_ready"}, 32'(bus.in_ready), 32'(tv[i].e_ir));
            @(posedge clk);
            #1;
            check({tv[i].name, ".valid"}, 32'(bus.out_valid), 32'(tv[i].e_v));
            if (tv[i].cd) begin
                check({tv[i].name, ".a"}, bus.out_a, tv[i].ea);
                check({tv[i].name, ".b"}, bus.out_b, tv[i].eb);
                check({tv[i].name, ".op"}, 32'(bus.out_op), 32'(tv[i].eop));
                check({tv[i].name, ".ill"}, 32'(bus.out_ill), 32'(tv[i].eill));
            end
        end

        // Reset while a stream is still flowing.
        drive(0, 0, 0, 1, 3, 4, 3'b010, 0, 0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", 32'(bus.out_valid), 32'h0);
        check("midrst_a", bus.out_a, 32'h0);
        check("midrst_op", 32'(bus.out_op), 32'h0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'h1);
        drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_idle", 32'(bus.out_valid), 32'h0);
        drive(0, 0, 0, 1, 3, 6, 3'b010, 0, 0, 1);
        @(posedge clk);
        #1;
        check("post_rst_valid", 32'(bus.out_valid), 32'h1);
        check("post_rst_r3", bus.out_a, 32'h0);
        check("post_rst_r6", bus.out_b, 32'h0);
        drive(0, 0, 0, 0, 0, 0, 3'b000, 0, 0, 1);
        @(posedge clk);
        #1;
        check("post_rst_drain", 32'(bus.out_valid), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
